// File: rtl/alu_pkg.sv
// Shared types for the ALU program sequencer: opcodes, NOP pair, FSM states.
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_OR  = 2'b10,
      ALU_XOR = 2'b11
   } alu_op_t;

   localparam alu_op_t    NOP_OP      = ALU_ADD;
   localparam logic [3:0] NOP_OPERAND = 4'h0;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } seq_state_t;

   typedef struct packed {
      alu_op_t    op;
      logic [3:0] operand;
   } prog_entry_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Program-load valid/ready port of the ALU op sequencer.
interface alu_op_sequencer_if;
   import alu_pkg::*;

   logic       load_valid;
   logic       load_ready;
   alu_op_t    load_op;
   logic [3:0] load_operand;

   modport master (
      output load_valid,
      output load_op,
      output load_operand,
      input  load_ready
   );

   modport slave (
      input  load_valid,
      input  load_op,
      input  load_operand,
      output load_ready
   );

endinterface

// File: rtl/alu_prog_mem.sv
// Program store: DEPTH x 6-bit register file, synchronous write, asynchronous read, no reset.
module alu_prog_mem
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          i_clock,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  prog_entry_t   i_wdata,
   input  logic [AW-1:0] i_raddr,
   output prog_entry_t   o_rdata
);

   prog_entry_t r_mem [DEPTH];

   always_ff @(posedge i_clock) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/alu_op_sequencer.sv
// Replays a loaded (op, operand) program into the accumulator ALU for 1..16 passes,
// driving the no-op pair (ADD, 0) whenever it is not executing.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned LW    = $clog2(DEPTH) + 1
) (
   input  logic                     i_clock,
   input  logic                     i_reset,
   alu_op_sequencer_if.slave        load_if,
   input  logic                     i_clear,
   input  logic                     i_start,
   input  logic                     i_abort,
   input  logic [3:0]               i_repeat_count,
   output logic                     o_busy,
   output logic                     o_done,
   output logic [LW-1:0]            o_prog_len,
   output alu_op_t                  o_alu_op,
   output logic [3:0]               o_alu_operand
);

   localparam int unsigned   AW       = $clog2(DEPTH);
   localparam logic [LW-1:0] DEPTH_LW = LW'(DEPTH);

   seq_state_t    r_state, w_state_next;
   logic [LW-1:0] r_prog_len, w_prog_len_next;
   logic [AW-1:0] r_rd_ptr, w_rd_ptr_next, w_raddr;
   logic [3:0]    r_pass, w_pass_next;
   alu_op_t       r_alu_op, w_alu_op_next;
   logic [3:0]    r_alu_operand, w_alu_operand_next;
   logic          r_busy, w_busy_next;
   logic          r_done, w_done_next;
   logic          w_load_ready, w_go, w_last, w_we;
   prog_entry_t   w_rdata, w_wdata;

   assign w_load_ready       = (r_state == IDLE) && (r_prog_len < DEPTH_LW);
   assign load_if.load_ready = w_load_ready;
   assign w_go               = i_start && (r_prog_len != '0);
   // r_rd_ptr names the entry currently on the outputs
   assign w_last             = ({1'b0, r_rd_ptr} == (r_prog_len - LW'(1)));
   assign w_wdata            = {load_if.load_op, load_if.load_operand};

   alu_prog_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_prog_mem (
      .i_clock (i_clock),
      .i_we    (w_we),
      .i_waddr (r_prog_len[AW-1:0]),
      .i_wdata (w_wdata),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata)
   );

   always_comb begin
      w_state_next       = r_state;
      w_prog_len_next    = r_prog_len;
      w_rd_ptr_next      = r_rd_ptr;
      w_pass_next        = r_pass;
      w_alu_op_next      = NOP_OP;
      w_alu_operand_next = NOP_OPERAND;
      w_busy_next        = 1'b0;
      w_done_next        = 1'b0;
      w_raddr            = '0;
      w_we               = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (w_go) begin
               w_state_next       = RUN;
               w_rd_ptr_next      = '0;
               w_pass_next        = i_repeat_count;
               w_alu_op_next      = w_rdata.op;
               w_alu_operand_next = w_rdata.operand;
               w_busy_next        = 1'b1;
            end else if (i_clear) begin
               w_prog_len_next = '0;
            end else if (load_if.load_valid && w_load_ready) begin
               w_we            = 1'b1;
               w_prog_len_next = r_prog_len + LW'(1);
            end
         end
         RUN: begin
            if (i_abort) begin
               w_state_next = IDLE;
            end else if (w_last && (r_pass == 4'd0)) begin
               w_state_next = DONE;
               w_done_next  = 1'b1;
            end else begin
               if (w_last) begin
                  w_rd_ptr_next = '0;
                  w_pass_next   = r_pass - 4'd1;
               end else begin
                  w_rd_ptr_next = r_rd_ptr + AW'(1);
               end
               w_raddr            = w_rd_ptr_next;
               w_alu_op_next      = w_rdata.op;
               w_alu_operand_next = w_rdata.operand;
               w_busy_next        = 1'b1;
            end
         end
         DONE: begin
            w_state_next = IDLE;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state       <= IDLE;
         r_prog_len    <= '0;
         r_rd_ptr      <= '0;
         r_pass        <= '0;
         r_alu_op      <= NOP_OP;
         r_alu_operand <= NOP_OPERAND;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
      end else begin
         r_state       <= w_state_next;
         r_prog_len    <= w_prog_len_next;
         r_rd_ptr      <= w_rd_ptr_next;
         r_pass        <= w_pass_next;
         r_alu_op      <= w_alu_op_next;
         r_alu_operand <= w_alu_operand_next;
         r_busy        <= w_busy_next;
         r_done        <= w_done_next;
      end
   end

   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_prog_len    = r_prog_len;
   assign o_alu_op      = r_alu_op;
   assign o_alu_operand = r_alu_operand;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed self-checking bench for alu_op_sequencer with a 4-bit accumulator ALU model.
module tb_alu_op_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       clear;
   logic       start;
   logic       abort;
   logic [3:0] repeat_count;
   logic       busy;
   logic       done;
   logic [3:0] prog_len;
   alu_op_t    alu_op;
   logic [3:0] alu_operand;
   logic [3:0] acc;
   logic [3:0] acc0;

   int n_checks = 0;
   int n_pass   = 0;

   alu_op_sequencer_if load_if ();

   alu_op_sequencer #(
      .DEPTH (8)
   ) dut (
      .i_clock        (clk),
      .i_reset        (rst),
      .load_if        (load_if),
      .i_clear        (clear),
      .i_start        (start),
      .i_abort        (abort),
      .i_repeat_count (repeat_count),
      .o_busy         (busy),
      .o_done         (done),
      .o_prog_len     (prog_len),
      .o_alu_op       (alu_op),
      .o_alu_operand  (alu_operand)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Accumulator ALU: consumes op/operand on every rising edge
   always @(posedge clk) begin
      if (rst) acc <= 4'h0;
      else begin
         case (alu_op)
            ALU_ADD: acc <= acc + alu_operand;
            ALU_SUB: acc <= acc - alu_operand;
            ALU_OR:  acc <= acc | alu_operand;
            default: acc <= acc ^ alu_operand;
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input alu_op_t op, input logic [3:0] operand);
      load_if.load_valid   = 1'b1;
      load_if.load_op      = op;
      load_if.load_operand = operand;
      step();
      load_if.load_valid   = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      start = 1'b1;
      load_if.load_valid = 1'b1;
      load_if.load_op = ALU_XOR;
      load_if.load_operand = 4'hf;
      step();
      step();
      rst = 1'b0;
      start = 1'b0;
      load_if.load_valid = 1'b0;
      n_checks++; if (alu_op !== ALU_ADD) $display("FAIL reset_op got %0h want 0", alu_op); else n_pass++;
      n_checks++; if (alu_operand !== 4'h0) $display("FAIL reset_operand got %0h want 0", alu_operand); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else n_pass++;
      n_checks++; if (load_if.load_ready !== 1'b1) $display("FAIL reset_ready got %0b want 1", load_if.load_ready); else n_pass++;
      n_checks++; if (prog_len !== 4'd0) $display("FAIL reset_prog_len got %0d want 0", prog_len); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0 || prog_len !== 4'd0) $display("FAIL reset_post got busy=%0b len=%0d want 0/0", busy, prog_len); else n_pass++;
   endtask

   task automatic test_basic();
      load(ALU_ADD, 4'd3);
      load(ALU_SUB, 4'd1);
      n_checks++; if (prog_len !== 4'd2) $display("FAIL basic_len got %0d want 2", prog_len); else n_pass++;
      repeat_count = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if (alu_op !== ALU_ADD || alu_operand !== 4'd3 || busy !== 1'b1) $display("FAIL basic_e0 got %0h/%0h busy=%0b want 0/3 busy=1", alu_op, alu_operand, busy); else n_pass++;
      step();
      n_checks++; if (alu_op !== ALU_SUB || alu_operand !== 4'd1 || busy !== 1'b1) $display("FAIL basic_e1 got %0h/%0h busy=%0b want 1/1 busy=1", alu_op, alu_operand, busy); else n_pass++;
      step();
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || alu_op !== ALU_ADD || alu_operand !== 4'd0) $display("FAIL basic_done got done=%0b busy=%0b %0h/%0h want 1/0 0/0", done, busy, alu_op, alu_operand); else n_pass++;
      n_checks++; if (acc !== 4'd2) $display("FAIL basic_acc got %0d want 2", acc); else n_pass++;
      step();
      n_checks++; if (done !== 1'b0 || load_if.load_ready !== 1'b1) $display("FAIL basic_idle got done=%0b ready=%0b want 0/1", done, load_if.load_ready); else n_pass++;
   endtask

   task automatic test_repeat();
      do_clear();
      load(ALU_ADD, 4'd5);
      repeat_count = 4'd2;
      acc0 = acc;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++; if (alu_op !== ALU_ADD || alu_operand !== 4'd5 || busy !== 1'b1) $display("FAIL repeat_pass%0d got %0h/%0h busy=%0b want 0/5 busy=1", i, alu_op, alu_operand, busy); else n_pass++;
         step();
      end
      n_checks++; if (done !== 1'b1 || busy !== 1'b0) $display("FAIL repeat_done got done=%0b busy=%0b want 1/0", done, busy); else n_pass++;
      n_checks++; if (acc !== 4'(acc0 + 4'd15)) $display("FAIL repeat_acc got %0d want %0d", acc, 4'(acc0 + 4'd15)); else n_pass++;
      step();
   endtask

   task automatic test_full();
      do_clear();
      for (int i = 0; i < 9; i++) begin
         n_checks++; if (load_if.load_ready !== (i < 8)) $display("FAIL full_ready%0d got %0b want %0b", i, load_if.load_ready, (i < 8)); else n_pass++;
         load(alu_op_t'(i[1:0]), 4'(i + 1));
      end
      n_checks++; if (prog_len !== 4'd8) $display("FAIL full_len got %0d want 8", prog_len); else n_pass++;
      repeat_count = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         n_checks++; if (alu_op !== alu_op_t'(i[1:0]) || alu_operand !== 4'(i + 1) || busy !== 1'b1) $display("FAIL full_e%0d got %0h/%0h busy=%0b want %0h/%0h busy=1", i, alu_op, alu_operand, busy, i[1:0], 4'(i + 1)); else n_pass++;
         step();
      end
      n_checks++; if (done !== 1'b1 || alu_operand !== 4'd0) $display("FAIL full_done got done=%0b operand=%0h want 1/0", done, alu_operand); else n_pass++;
      step();
   endtask

   task automatic test_abort();
      do_clear();
      load(ALU_ADD, 4'd1);
      load(ALU_SUB, 4'd2);
      load(ALU_OR, 4'd4);
      load(ALU_XOR, 4'd8);
      repeat_count = 4'd3;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (5) step();
      n_checks++; if (alu_op !== ALU_SUB || alu_operand !== 4'd2 || busy !== 1'b1) $display("FAIL abort_c6 got %0h/%0h busy=%0b want 1/2 busy=1", alu_op, alu_operand, busy); else n_pass++;
      abort = 1'b1;
      step();
      abort = 1'b0;
      n_checks++; if (alu_op !== ALU_ADD || alu_operand !== 4'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL abort_nop got %0h/%0h busy=%0b done=%0b want 0/0 0 0", alu_op, alu_operand, busy, done); else n_pass++;
      step();
      n_checks++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL abort_nodone got done=%0b busy=%0b want 0/0", done, busy); else n_pass++;
      repeat_count = 4'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if (alu_op !== ALU_ADD || alu_operand !== 4'd1 || busy !== 1'b1) $display("FAIL abort_replay got %0h/%0h busy=%0b want 0/1 busy=1", alu_op, alu_operand, busy); else n_pass++;
      repeat (4) step();
      n_checks++; if (done !== 1'b1) $display("FAIL abort_replay_done got %0b want 1", done); else n_pass++;
      step();
   endtask

   task automatic test_edges();
      do_clear();
      start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if (busy !== 1'b0 || alu_op !== ALU_ADD || alu_operand !== 4'd0) $display("FAIL empty_start got busy=%0b %0h/%0h want 0 0/0", busy, alu_op, alu_operand); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL empty_idle got busy=%0b done=%0b want 0/0", busy, done); else n_pass++;
      load(ALU_ADD, 4'd9);
      clear = 1'b1;
      load(ALU_SUB, 4'd6);
      clear = 1'b0;
      n_checks++; if (prog_len !== 4'd0) $display("FAIL clear_wins got %0d want 0", prog_len); else n_pass++;
      load(ALU_ADD, 4'd7);
      load(ALU_XOR, 4'd3);
      repeat_count = 4'd5;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      n_checks++; if (busy !== 1'b1 || alu_op !== ALU_XOR || alu_operand !== 4'd3) $display("FAIL midrun got busy=%0b %0h/%0h want 1 3/3", busy, alu_op, alu_operand); else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      n_checks++; if (alu_op !== ALU_ADD || alu_operand !== 4'd0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL midrun_reset_out got %0h/%0h busy=%0b done=%0b want 0/0 0 0", alu_op, alu_operand, busy, done); else n_pass++;
      n_checks++; if (prog_len !== 4'd0 || load_if.load_ready !== 1'b1) $display("FAIL midrun_reset_len got len=%0d ready=%0b want 0/1", prog_len, load_if.load_ready); else n_pass++;
      step();
      n_checks++; if (busy !== 1'b0) $display("FAIL midrun_reset_idle got busy=%0b want 0", busy); else n_pass++;
   endtask

   initial begin
      rst = 1'b1;
      clear = 1'b0;
      start = 1'b0;
      abort = 1'b0;
      repeat_count = 4'd0;
      load_if.load_valid = 1'b0;
      load_if.load_op = ALU_ADD;
      load_if.load_operand = 4'd0;
      test_reset();
      test_basic();
      test_repeat();
      test_full();
      test_abort();
      test_edges();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
